// File: rtl/median_ctrl_pkg.sv
// rtl/median_ctrl_pkg.sv - shared state encoding and border test for the median window sequencer
package median_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        WAIT_OUT
    } state_t;

    function automatic logic is_border(input int col, input int row, input int w, input int h);
        return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
    endfunction

endpackage

// File: rtl/median_pos_cnt.sv
// rtl/median_pos_cnt.sv - raster col/row counter with wrap, synchronous clear and enable
module median_pos_cnt #(
    parameter int W     = 480,
    parameter int H     = 272,
    parameter int CNT_W = 9
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(H - 1);

    always_ff @(posedge sclk) begin
        if (!s_rst_n || clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/median_win_ctrl.sv
// rtl/median_win_ctrl.sv - 3x3 median frame sequencer; optional watchdog via MEDIAN_CTRL_TIMEOUT_EN
module median_win_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int IMG_W       = 480,
    parameter int IMG_H       = 272,
    parameter int CNT_W       = 9,
    parameter int OCNT_W      = 17,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic             dout_flag_i,
    output logic             lb_wr_en,
    output logic             lb_rd_en,
    output logic             win_valid,
    output logic             border,
    output logic [CNT_W-1:0] ccol,
    output logic [CNT_W-1:0] crow,
    output logic             vsync,
    output logic             frame_done,
    output logic             err_overrun,
    output logic             err_timeout
);

    localparam logic [CNT_W-1:0]  LAST_COL   = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0]  LAST_ROW   = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(IMG_W);
    localparam logic [OCNT_W-1:0] TOTAL      = OCNT_W'(IMG_W * IMG_H);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t           state;
    logic [CNT_W-1:0] in_col, in_row, c_col, c_row, flush_cnt;
    logic [OCNT_W-1:0] out_cnt, out_cnt_nxt;
    logic             in_active, accept, past_fill, emit, last_px;

    assign in_active = (state == FILL) || (state == RUN);
    assign accept    = in_valid && in_active && !frame_start;
    assign lb_wr_en  = accept;
    assign lb_rd_en  = accept && (in_row != '0);

    // Centre lags input by IMG_W+1 pixels: this pixel's index is at least IMG_W+1.
    assign past_fill = (in_row > CNT_W'(1)) || ((in_row == CNT_W'(1)) && (in_col != '0));
    assign emit      = (accept && past_fill) || ((state == FLUSH) && !frame_start);
    assign last_px   = (in_row == LAST_ROW) && (in_col == LAST_COL);

    always_comb begin
        out_cnt_nxt = out_cnt;
        if (dout_flag_i && (state != IDLE) && (out_cnt != TOTAL))
            out_cnt_nxt = out_cnt + 1'b1;
    end

    median_pos_cnt #(.W(IMG_W), .H(IMG_H), .CNT_W(CNT_W)) u_in_pos (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .clr     (frame_start),
        .en      (accept),
        .col     (in_col),
        .row     (in_row)
    );

    median_pos_cnt #(.W(IMG_W), .H(IMG_H), .CNT_W(CNT_W)) u_ctr_pos (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .clr     (frame_start),
        .en      (emit),
        .col     (c_col),
        .row     (c_row)
    );

`ifdef MEDIAN_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            out_cnt     <= '0;
            vsync       <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            win_valid   <= 1'b0;
            border      <= 1'b0;
            ccol        <= '0;
            crow        <= '0;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            win_valid  <= emit;
            border     <= emit && is_border(int'(c_col), int'(c_row), IMG_W, IMG_H);
            if (emit) begin
                ccol <= c_col;
                crow <= c_row;
            end
            out_cnt <= out_cnt_nxt;

            if (frame_start) begin
                // Restart wins over everything, including a coincident last output.
                state       <= FILL;
                flush_cnt   <= '0;
                out_cnt     <= '0;
                vsync       <= 1'b1;
                err_overrun <= 1'b0;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
                wd_cnt      <= '0;
                err_timeout <= 1'b0;
`endif
            end else begin
                if (in_valid && ((state == FLUSH) || (state == WAIT_OUT)))
                    err_overrun <= 1'b1;
                case (state)
                    IDLE: ;
                    FILL: begin
                        if (accept && (in_row == '0) && (in_col == LAST_COL))
                            state <= RUN;
                    end
                    RUN: begin
                        if (accept && last_px) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state <= WAIT_OUT;
`ifdef MEDIAN_CTRL_TIMEOUT_EN
                            wd_cnt <= '0;
`endif
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    WAIT_OUT: begin
                        if (out_cnt_nxt == TOTAL) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            vsync      <= 1'b0;
                        end
`ifdef MEDIAN_CTRL_TIMEOUT_EN
                        else if (dout_flag_i) begin
                            wd_cnt <= '0;
                        end else if (wd_cnt == WD_LAST) begin
                            state       <= IDLE;
                            frame_done  <= 1'b1;
                            vsync       <= 1'b0;
                            err_timeout <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
